// File: rtl/arm_code_writer.sv
// arm_code_writer: serialises translated ARM instruction bundles into a word-addressed code memory.
// Define ARM_CODE_WRITER_TRACE_EN to log each committed or discarded word.
module arm_code_writer #(
    parameter int BUNDLE_WORDS = 6,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write_enable,
    input  logic [32*BUNDLE_WORDS-1:0]   instructions,
    input  logic [3:0]                   quantity,
    output logic                         ready,
    output logic                         mem_we,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [31:0]                  mem_wdata,
    output logic [ADDR_WIDTH:0]          word_count,
    output logic                         full,
    output logic                         overflow,
    output logic                         dropped,
    output logic                         bad_quantity
);
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [3:0] MAX_Q = 4'(BUNDLE_WORDS);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                      state, state_next;
    logic                        we_prev;
    logic [32*BUNDLE_WORDS-1:0]  bundle_q;
    logic [3:0]                  rem_q;
    logic                        capture, accept, emit, too_many;

    assign capture  = write_enable && !we_prev;
    assign too_many = quantity > MAX_Q;
    assign ready    = state == IDLE;
    assign full     = word_count == DEPTH;

    // DRAIN lasts one cycle beyond the last word so ready rises as mem_we falls
    always_comb begin
        state_next = state;
        accept     = state == IDLE && capture && quantity != 4'd0;
        emit       = state == DRAIN && rem_q != 4'd0;
        if (accept)
            state_next = DRAIN;
        else if (state == DRAIN && rem_q == 4'd0)
            state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            we_prev      <= 1'b0;
            bundle_q     <= '0;
            rem_q        <= 4'd0;
            word_count   <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            overflow     <= 1'b0;
            dropped      <= 1'b0;
            bad_quantity <= 1'b0;
        end else begin
            state   <= state_next;
            we_prev <= write_enable;
            mem_we  <= emit && !full;
            if (accept) begin
                bundle_q <= instructions;
                rem_q    <= too_many ? MAX_Q : quantity;
                if (too_many)
                    bad_quantity <= 1'b1;
            end
            // lowest slice leaves first; the bundle shifts down one word per cycle
            if (emit) begin
                bundle_q <= bundle_q >> 32;
                rem_q    <= rem_q - 4'd1;
                if (full) begin
                    overflow <= 1'b1;
                end else begin
                    mem_addr   <= word_count[ADDR_WIDTH-1:0];
                    mem_wdata  <= bundle_q[31:0];
                    word_count <= word_count + 1'b1;
                end
            end
            if (state == DRAIN && capture)
                dropped <= 1'b1;
        end
    end

`ifdef ARM_CODE_WRITER_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && emit) begin
            if (full)
                $display("OVERFLOW");
            else
                $display("%b %0d", bundle_q[31:0], word_count[ADDR_WIDTH-1:0]);
        end
    end
`else
`endif

endmodule
